// File: rtl/lbm_pkg.sv
// Shared types for the LBM step datapath: sequencer state encoding and mux select width.
// No logic; types and constants only.
// Imported by every block that touches the final-address mux.
package lbm_pkg;

    // Width of the final-address mux select (11 sources fit in 4 bits).
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fin_addr_seq.sv
// Walks final-address mux sources 0..NUM_SRC-1 for every lattice node, one memory request per source.
// Latency: first request 1 cycle after start; NUM_SRC+1 cycles per node when unstalled; done 1 cycle after last commit.
// Backpressure: mem_ready low holds select/node_idx and req_valid indefinitely; abort returns to IDLE from any state.
module fin_addr_seq
    import lbm_pkg::*;
#(
    parameter  int NUM_SRC    = 11,
    parameter  int NODE_COUNT = 64,
    localparam int NODE_W     = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mem_ready,
    output logic [SEL_W-1:0]  select,
    output logic              req_valid,
    output logic [NODE_W-1:0] node_idx,
    output logic              commit,
    output logic              busy,
    output logic              done
);

    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_SRC - 1);
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NODE_COUNT - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [NODE_W-1:0] node_nxt;

    // State and both counters advance together so select/node_idx stay aligned with the state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            select   <= '0;
            node_idx <= '0;
        end else begin
            state    <= state_nxt;
            select   <= sel_nxt;
            node_idx <= node_nxt;
        end
    end

    // Next-state and counter update; abort overrides everything, including a same-cycle handshake.
    always_comb begin
        state_nxt = state;
        sel_nxt   = select;
        node_nxt  = node_idx;
        if (abort) begin
            state_nxt = IDLE;
            sel_nxt   = '0;
            node_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = ISSUE;
                        sel_nxt   = '0;
                        node_nxt  = '0;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        if (select == LAST_SEL) begin
                            // Last source accepted: select holds through the commit cycle.
                            state_nxt = COMMIT;
                        end else begin
                            sel_nxt = select + SEL_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    if (node_idx == LAST_NODE) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                        node_nxt  = node_idx + NODE_W'(1);
                        sel_nxt   = '0;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    node_nxt  = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    node_nxt  = '0;
                end
            endcase
        end
    end

    // Outputs decoded purely from the registered state, so they are glitch-free and input-independent.
    always_comb begin
        req_valid = (state == ISSUE);
        commit    = (state == COMMIT);
        done      = (state == DONE);
        busy      = (state != IDLE);
    end

endmodule
